// File: rtl/fp_pkg.sv
// Shared floating-point definitions: word width, adder op encodings and the
// in-flight tag carried alongside the shared adder's pipeline.
package fp_pkg;

    localparam int FP_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// granted index and wraps, so the first eligible requester wins.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_any
);

    logic [N-1:0] w_upper;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick;
    logic         w_found;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_upper    = '0;
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_upper[i] = (IDW'(i) > i_last);
        end
        // Prefer requesters above the last grant; otherwise wrap to index 0.
        w_masked = i_req & w_upper;
        w_pick   = (|w_masked) ? w_masked : i_req;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i] && !w_found) begin
                o_grant[i] = 1'b1;
                o_grant_id = IDW'(i);
                w_found    = 1'b1;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/f_add_sched.sv
// Shares one fixed-latency floating-point adder among NUM_REQ requesters,
// each allowed a single outstanding op returned in a private response register.
module f_add_sched
    import fp_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADD_LAT = 1,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_in0,
    input  logic [NUM_REQ*FP_W-1:0] req_in1,
    input  logic [NUM_REQ-1:0]      req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*FP_W-1:0] rsp_data,
    output logic [FP_W-1:0]         add_in0,
    output logic [FP_W-1:0]         add_in1,
    output logic                    add_op,
    input  logic [FP_W-1:0]         add_out,
    output logic [NUM_REQ-1:0]      busy
);

    logic [NUM_REQ-1:0]      w_eligible;
    logic [NUM_REQ-1:0]      w_grant;
    logic [IDW-1:0]          w_grant_id;
    logic                    w_any;
    logic [IDW-1:0]          r_last_grant;
    logic [NUM_REQ-1:0]      r_busy;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [NUM_REQ*FP_W-1:0] r_rsp_data;
    tag_t                    r_tag [ADD_LAT];
    tag_t                    w_done;

    // Gating with rst keeps a requester from seeing an accept that reset discards.
    assign w_eligible = req_valid & ~r_busy & {NUM_REQ{~rst}};

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req      (w_eligible),
        .i_last     (r_last_grant),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        add_in0 = '0;
        add_in1 = '0;
        add_op  = OP_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                add_in0 = req_in0[i*FP_W +: FP_W];
                add_in1 = req_in1[i*FP_W +: FP_W];
                add_op  = req_op[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDW'(NUM_REQ - 1);
        end else if (w_any) begin
            r_last_grant <= w_grant_id;
        end
    end

    // NOTE: the tag pipe is a small register array, not RAM; every stage is
    // reset so that in-flight results are dropped by a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ADD_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_any, id: TAG_ID_W'(w_grant_id)};
            for (int s = 1; s < ADD_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // The final tag stage lines up with the cycle in which add_out is valid.
    assign w_done = r_tag[ADD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_done.valid && (w_done.id == TAG_ID_W'(k))) begin
                    r_rsp_data[k*FP_W +: FP_W] <= add_out;
                    r_rsp_valid[k]             <= 1'b1;
                end else if (r_rsp_valid[k] && rsp_ready[k]) begin
                    r_rsp_valid[k] <= 1'b0;
                end
                // Grant and response handshake never coincide for one requester.
                if (w_grant[k]) begin
                    r_busy[k] <= 1'b1;
                end else if (r_rsp_valid[k] && rsp_ready[k]) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule
